// File: rtl/mio_arb_pkg.sv
// Shared encodings for the MIO bus arbiter: FSM states, owner codes and wait-counter width.
// Round-robin selection is enabled by defining MIO_ARB_RR_EN (see mio_arb_pick).
package mio_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DEV  = 2'b10
    } owner_t;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mio_arb_pick.sv
// Combinational winner select between the CPU and device masters.
// MIO_ARB_RR_EN defined: ties alternate via last_grant; undefined: DEV always wins ties.
module mio_arb_pick
    import mio_arb_pkg::*;
(
    input  logic   cpu_req,
    input  logic   dev_req,
    input  owner_t last_grant,
    output owner_t winner
);

`ifdef MIO_ARB_RR_EN
    always_comb begin
        winner = OWN_NONE;
        if (cpu_req && dev_req) begin
            winner = (last_grant == OWN_CPU) ? OWN_DEV : OWN_CPU;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else if (dev_req) begin
            winner = OWN_DEV;
        end
    end
`else
    // last_grant is tracked by the top but plays no part in fixed priority.
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        winner = OWN_NONE;
        if (dev_req) begin
            winner = OWN_DEV;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end
    end
`endif

endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares one MIO port between the CPU and a device master: IDLE -> ACCESS -> RESP.
// Tie policy comes from mio_arb_pick and is switched by the MIO_ARB_RR_EN macro.
module mio_bus_arbiter
    import mio_arb_pkg::*;
#(
    parameter int WAIT_CYC = 2,
    parameter int AW       = 32,
    parameter int DW       = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ready,
    input  logic          dev_req,
    input  logic          dev_we,
    input  logic [AW-1:0] dev_addr,
    input  logic [DW-1:0] dev_wdata,
    output logic [DW-1:0] dev_rdata,
    output logic          dev_ready,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner,
    output logic [1:0]    state_out
);

    // Handshake: a master raises req and holds it (with we/addr/wdata stable) until
    // it sees its ready high for one cycle; req is only sampled in IDLE, so changes
    // during ACCESS/RESP are ignored and a latched transaction always completes.

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYC - 1);

    state_t           state;
    owner_t           own;
    owner_t           last_grant;
    owner_t           winner;
    logic [CNT_W-1:0] cnt;

    mio_arb_pick u_pick (
        .cpu_req    (cpu_req),
        .dev_req    (dev_req),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            own        <= OWN_NONE;
            last_grant <= OWN_DEV;
            cnt        <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rdata  <= '0;
            dev_rdata  <= '0;
            cpu_ready  <= 1'b0;
            dev_ready  <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            dev_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (winner != OWN_NONE) begin
                        own    <= winner;
                        cnt    <= CNT_LOAD;
                        state  <= ST_ACCESS;
                        mem_en <= 1'b1;
                        if (winner == OWN_CPU) begin
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end else begin
                            mem_we    <= dev_we;
                            mem_addr  <= dev_addr;
                            mem_wdata <= dev_wdata;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt == '0) begin
                        // mem_we still holds the latched direction on the last access cycle.
                        if (!mem_we) begin
                            if (own == OWN_CPU) cpu_rdata <= mem_rdata;
                            else                dev_rdata <= mem_rdata;
                        end
                        if (own == OWN_CPU) cpu_ready <= 1'b1;
                        else                dev_ready <= 1'b1;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= ST_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RESP: begin
                    last_grant <= own;
                    own        <= OWN_NONE;
                    state      <= ST_IDLE;
                end
                default: begin
                    state  <= ST_IDLE;
                    own    <= OWN_NONE;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign owner     = own;
    assign state_out = state;

endmodule
